sysid_check_master: RTL and testbench

//  Avalon-MM read master that interrogates a system-ID slave (word 0 = ID, word 1 = build timestamp).

---
 rtl/sysid_check_master.sv | 169 ++++++++++++++++
 tb/tb_sysid_check_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// sysid_check_master
// Avalon-MM read master that reads the system-ID slave (word 0 = ID, word 1 = build timestamp)
// and compares both words against the expected image identity. One check runs per accepted
// start pulse. Every read has a cycle timeout and a bounded number of retries.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   start               begin a check (sampled only while idle)
//   avm_*               Avalon-MM read master towards the sysid slave
//   busy                high while a check is in progress (any state but idle)
//   done                one-cycle pulse at the end of every check
//   pass                both words matched; held until the next start
//   timeout_err         a read ran out of retries; held until the next start
//   id_value            captured word 0; held until the next start
//   timestamp_value     captured word 1; held until the next start
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1463451056,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  // Keep the retry counter at least one bit wide so MAX_RETRIES = 0 still elaborates.
  localparam int unsigned RtyW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT_CYCLES);
  localparam logic [RtyW-1:0] RtyLimit = RtyW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle,
    StReqId,
    StWaitId,
    StReqTs,
    StWaitTs,
    StCheck,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [RtyW-1:0] rty_q, rty_d;
  logic            pass_q, pass_d;
  logic            terr_q, terr_d;
  logic [31:0]     id_q, id_d;
  logic [31:0]     ts_q, ts_d;

  logic is_ts;
  logic is_req;
  logic tmo_hit;

  assign is_ts   = (state_q == StReqTs) || (state_q == StWaitTs);
  assign is_req  = (state_q == StReqId) || (state_q == StReqTs);
  assign tmo_hit = (tmo_q == TmoLimit);

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    rty_d       = rty_q;
    pass_d      = pass_q;
    terr_d      = terr_q;
    id_d        = id_q;
    ts_d        = ts_q;
    avm_read    = 1'b0;
    avm_address = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReqId;
          tmo_d   = '0;
          rty_d   = '0;
          pass_d  = 1'b0;
          terr_d  = 1'b0;
          id_d    = '0;
          ts_d    = '0;
        end
      end

      StReqId, StReqTs, StWaitId, StWaitTs: begin
        avm_address = (state_q == StReqTs);
        // Counter saturates at the limit; the limit cycle itself is the abort cycle.
        tmo_d = tmo_hit ? tmo_q : tmo_q + 1'b1;
        if (tmo_hit) begin
          // Abort: read stays low this cycle, then retry the same word or give up.
          if (rty_q < RtyLimit) begin
            rty_d   = rty_q + 1'b1;
            tmo_d   = '0;
            state_d = is_ts ? StReqTs : StReqId;
          end else begin
            terr_d  = 1'b1;
            pass_d  = 1'b0;
            state_d = StDone;
          end
        end else if (is_req) begin
          avm_read = 1'b1;
          if (!avm_waitrequest) begin
            state_d = is_ts ? StWaitTs : StWaitId;
          end
        end else if (avm_readdatavalid) begin
          rty_d = '0;
          if (is_ts) begin
            ts_d    = avm_readdata;
            state_d = StCheck;
          end else begin
            id_d    = avm_readdata;
            tmo_d   = '0;
            state_d = StReqTs;
          end
        end
      end

      StCheck: begin
        pass_d  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP);
        state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      rty_q   <= '0;
      pass_q  <= 1'b0;
      terr_q  <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      rty_q   <= rty_d;
      pass_q  <= pass_d;
      terr_q  <= terr_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);
  assign pass            = pass_q;
  assign timeout_err     = terr_q;
  assign id_value        = id_q;
  assign timestamp_value = ts_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Self-checking bench for sysid_check_master: a behavioural sysid slave with configurable wait
// states, response latency and data, plus a reference model of the expected check outcome.
module tb_sysid_check_master;

  localparam logic [31:0] ExpId     = 32'h0000_0000;
  localparam logic [31:0] ExpTs     = 32'd1463451056;
  localparam int unsigned TmoCycles = 16;
  localparam int unsigned Retries   = 2;
  localparam int          DoneLimit = 200;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;

  int n_checks = 0;
  int n_pass   = 0;

  // Slave configuration
  logic [31:0] cfg_data [2];
  int          cfg_ws   [2];
  int          cfg_lat;
  bit          cfg_respond;
  int          acc_cnt  [2] = '{0, 0};

  always #5 clock = ~clock;

  sysid_check_master #(
    .EXPECTED_ID       (ExpId),
    .EXPECTED_TIMESTAMP(ExpTs),
    .TIMEOUT_CYCLES    (TmoCycles),
    .MAX_RETRIES       (Retries)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .timeout_err      (timeout_err),
    .id_value         (id_value),
    .timestamp_value  (timestamp_value)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_cfg(input logic [31:0] d0, input logic [31:0] d1, input int ws0,
                         input int ws1, input int lat, input bit respond);
    cfg_data[0] = d0;
    cfg_data[1] = d1;
    cfg_ws[0]   = ws0;
    cfg_ws[1]   = ws1;
    cfg_lat     = lat;
    cfg_respond = respond;
  endtask

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_busy"}, 32'(busy), 0);
    check_eq({pfx, "_done"}, 32'(done), 0);
    check_eq({pfx, "_pass"}, 32'(pass), 0);
    check_eq({pfx, "_timeout_err"}, 32'(timeout_err), 0);
    check_eq({pfx, "_id_value"}, id_value, 0);
    check_eq({pfx, "_timestamp_value"}, timestamp_value, 0);
    check_eq({pfx, "_avm_read"}, 32'(avm_read), 0);
    check_eq({pfx, "_avm_address"}, 32'(avm_address), 0);
  endtask

  // Slave: decides waitrequest/readdatavalid for each cycle just after the clock edge.
  initial begin : slave
    bit last_acc, last_addr, pend, paddr, hold, hold_addr, loaded, wr;
    int timer, ws_left;
    last_acc = 0; last_addr = 0; pend = 0; paddr = 0; hold = 0; hold_addr = 0; loaded = 0;
    timer = 0; ws_left = 0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(posedge clock);
      #1;
      if (last_acc) begin
        acc_cnt[last_addr]++;
        pend  = cfg_respond;
        timer = cfg_lat;
        paddr = last_addr;
      end
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (pend) begin
        if (timer == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = cfg_data[paddr];
          pend              = 0;
        end else begin
          timer--;
        end
      end
      if (hold) begin
        check_eq("hold_read", 32'(avm_read), 1);
        check_eq("hold_address", 32'(avm_address), 32'(hold_addr));
      end
      wr = 0;
      if (!avm_read) begin
        loaded = 0;
      end else begin
        if (!loaded) begin
          ws_left = cfg_ws[avm_address];
          loaded  = 1;
        end
        if (ws_left > 0) begin
          wr = 1;
          ws_left--;
        end
      end
      avm_waitrequest = wr;
      last_acc  = avm_read && !wr;
      last_addr = avm_address;
      hold      = avm_read && wr;
      hold_addr = avm_address;
    end
  end

  // Runs one check and compares against the model. extra[j] drives start sampled at edge N+j.
  task automatic run_check(input logic [15:0] extra, input int idle_watch);
    int k, a0, a1, exp_lat, quiet_err;
    bit exp_pass;
    logic [31:0] exp_id, exp_ts;
    a0 = acc_cnt[0];
    a1 = acc_cnt[1];
    if (cfg_respond) begin
      exp_id   = cfg_data[0];
      exp_ts   = cfg_data[1];
      exp_pass = (exp_id == ExpId) && (exp_ts == ExpTs);
      // Each read: wait states + accept edge, response latency + capture edge; then CHECK edge.
      exp_lat  = (cfg_ws[0] + 1 + cfg_lat + 1) + (cfg_ws[1] + 1 + cfg_lat + 1) + 1;
    end else begin
      exp_id   = '0;
      exp_ts   = '0;
      exp_pass = 0;
      exp_lat  = 0;
    end
    start = 1'b1;
    @(posedge clock);
    #2;
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 1);
    k = 0;
    while (!done && k < DoneLimit) begin
      start = (k < 15) ? extra[4'(k + 1)] : 1'b0;
      @(posedge clock);
      #2;
      start = 1'b0;
      k++;
    end
    check_eq("done_seen", 32'(done), 1);
    check_eq("pass", 32'(pass), 32'(exp_pass));
    check_eq("timeout_err", 32'(timeout_err), 32'(!cfg_respond));
    check_eq("id_value", id_value, exp_id);
    check_eq("timestamp_value", timestamp_value, exp_ts);
    check_eq("id_requests", acc_cnt[0] - a0, cfg_respond ? 1 : int'(Retries) + 1);
    check_eq("ts_requests", acc_cnt[1] - a1, cfg_respond ? 1 : 0);
    if (cfg_respond) check_eq("done_latency", k, exp_lat);
    start = (k < 15) ? extra[4'(k + 1)] : 1'b0;
    @(posedge clock);
    #2;
    start = 1'b0;
    check_eq("done_one_cycle", 32'(done), 0);
    check_eq("busy_idle", 32'(busy), 0);
    check_eq("pass_held", 32'(pass), 32'(exp_pass));
    quiet_err = 0;
    for (int i = 0; i < idle_watch; i++) begin
      @(posedge clock);
      #2;
      if (done || busy) quiet_err++;
    end
    check_eq("idle_quiet", quiet_err, 0);
  endtask

  initial begin : main
    int a1, k;
    logic [31:0] rid, rts;
    start = 1'b0;
    reset = 1'b1;
    set_cfg(ExpId, ExpTs, 0, 0, 0, 1'b1);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    check_reset_values("reset");

    // Zero-wait slave, correct image
    run_check(16'h0, 2);
    // Wrong timestamp
    set_cfg(ExpId, 32'h1234_5678, 0, 0, 0, 1'b1);
    run_check(16'h0, 2);
    // Slave stalls word 1 for 10 cycles
    set_cfg(ExpId, ExpTs, 0, 10, 0, 1'b1);
    run_check(16'h0, 2);

    // Randomized slave timing and data
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: begin rid = ExpId; rts = ExpTs; end
        1: begin rid = $urandom; rts = ExpTs; end
        2: begin rid = ExpId; rts = ExpTs ^ (32'd1 << $urandom_range(0, 31)); end
        default: begin rid = $urandom; rts = $urandom; end
      endcase
      set_cfg(rid, rts, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 3)), 1'b1);
      run_check(16'h0, 2);
    end

    // Slave never returns data: all retries used on word 0
    set_cfg(ExpId, ExpTs, 0, 0, 0, 1'b0);
    run_check(16'h0, 3);

    // start while busy (edges N+2, N+5) and in the DONE cycle (N+6) is ignored
    set_cfg(ExpId, ExpTs, 0, 0, 0, 1'b1);
    run_check(16'b0000_0000_0110_0100, 20);
    run_check(16'h0, 2);

    // Reset while waiting for word 1, followed by a stray readdatavalid
    set_cfg(32'hDEAD_BEEF, ExpTs, 0, 0, 4, 1'b1);
    a1 = acc_cnt[1];
    start = 1'b1;
    @(posedge clock);
    #2;
    start = 1'b0;
    k = 0;
    while (acc_cnt[1] == a1 && k < DoneLimit) begin
      @(posedge clock);
      #2;
      k++;
    end
    check_eq("mid_reset_ts_accepted", acc_cnt[1] - a1, 1);
    check_eq("mid_reset_id_before", id_value, 32'hDEAD_BEEF);
    reset = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    check_reset_values("mid_reset");
    set_cfg(ExpId, ExpTs, 0, 0, 0, 1'b1);
    run_check(16'h0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
